pipelined_adder_sub: RTL and testbench

//  Parametrised, pipelined two's-complement add/subtract unit. Successor to the fixed 6-bit combinational adder benchmark.

---
 rtl/adder_pkg.sv | 31 +++
 rtl/adder_seg.sv | 28 ++
 rtl/pipelined_adder_sub.sv | 125 ++++++++++++
 tb/tb_pipelined_adder_sub.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared segment arithmetic and stage-register flag layout for the pipelined add/subtract unit.
package adder_pkg;

    localparam int DEF_WIDTH  = 6;
    localparam int DEF_STAGES = 2;

    function automatic int seg_span(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    localparam int SEG_W = seg_span(DEF_WIDTH, DEF_STAGES);

    function automatic int seg_lo(input int k, input int width, input int stages);
        return k * seg_span(width, stages);
    endfunction

    // Later stages can own zero bits when ceil(WIDTH/STAGES) overshoots; they just pass through.
    function automatic int seg_w(input int k, input int width, input int stages);
        int rem;
        rem = width - seg_lo(k, width, stages);
        if (rem <= 0) return 0;
        return (rem < seg_span(width, stages)) ? rem : seg_span(width, stages);
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
        logic msbCarry;
    } stage_flags_t;

endpackage

// File: rtl/adder_seg.sv
// Combinational ripple-carry slice; also reports the carry into its top bit for overflow.
module adder_seg #(
    parameter int W = 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_s,
    output logic         o_cout,
    output logic         o_cMsb
);

    logic [W:0] w_c;

    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < W; i++) begin
            o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[W];
    assign o_cMsb = w_c[W-1];

endmodule

// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement add/subtract: STAGES registered carry segments with valid/ready at both ends.
module pipelined_adder_sub #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    import adder_pkg::*;

    logic [WIDTH-1:0] w_sumQ [STAGES];
    logic [WIDTH-1:0] w_aQ   [STAGES];
    logic [WIDTH-1:0] w_bQ   [STAGES];
    stage_flags_t     w_flgQ [STAGES];
    logic [STAGES-1:0] w_vQ;
    logic [STAGES-1:0] w_rdy;

    // Ready ripples back from the consumer: a stage accepts when empty or when its beat moves on.
    always_comb begin
        logic down;
        w_rdy = '0;
        down  = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = !w_vQ[k] || down;
            down     = w_rdy[k];
        end
    end

    assign in_ready  = w_rdy[0] && !flush_i;
    assign out_valid = w_flgQ[STAGES-1].valid;
    assign sum_o     = w_sumQ[STAGES-1];
    assign cout_o    = w_flgQ[STAGES-1].carry;
    assign ovf_o     = w_flgQ[STAGES-1].carry ^ w_flgQ[STAGES-1].msbCarry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = seg_lo(k, WIDTH, STAGES);
        localparam int SW = seg_w(k, WIDTH, STAGES);

        logic [WIDTH-1:0] w_pSum, w_pA, w_pB, w_nSum;
        logic             w_pC, w_pMsb, w_pV, w_nC, w_nMsb;
        logic [WIDTH-1:0] r_sum, r_a, r_b;
        stage_flags_t     r_flg;

        // Subtraction is folded in at entry: B and the borrow are inverted once, then every stage just adds.
        if (k == 0) begin : g_src
            assign w_pSum = '0;
            assign w_pA   = a_i;
            assign w_pB   = sub_i ? ~b_i : b_i;
            assign w_pC   = cin_i ^ sub_i;
            assign w_pMsb = 1'b0;
            assign w_pV   = in_valid && in_ready;
        end else begin : g_chain
            assign w_pSum = w_sumQ[k-1];
            assign w_pA   = w_aQ[k-1];
            assign w_pB   = w_bQ[k-1];
            assign w_pC   = w_flgQ[k-1].carry;
            assign w_pMsb = w_flgQ[k-1].msbCarry;
            assign w_pV   = w_vQ[k-1];
        end

        if (SW > 0) begin : g_seg
            logic [SW-1:0] w_s;
            logic          w_c, w_m;

            adder_seg #(.W(SW)) u_seg (
                .i_a    (w_pA[LO +: SW]),
                .i_b    (w_pB[LO +: SW]),
                .i_cin  (w_pC),
                .o_s    (w_s),
                .o_cout (w_c),
                .o_cMsb (w_m)
            );

            always_comb begin
                w_nSum           = w_pSum;
                w_nSum[LO +: SW] = w_s;
            end
            assign w_nC   = w_c;
            assign w_nMsb = (LO + SW == WIDTH) ? w_m : w_pMsb;
        end else begin : g_pass
            assign w_nSum = w_pSum;
            assign w_nC   = w_pC;
            assign w_nMsb = w_pMsb;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_flg <= '0;
                r_sum <= '0;
                r_a   <= '0;
                r_b   <= '0;
            end else if (flush_i) begin
                r_flg.valid <= 1'b0;
            end else if (w_rdy[k]) begin
                r_flg.valid <= w_pV;
                if (w_pV) begin
                    r_sum          <= w_nSum;
                    r_a            <= w_pA;
                    r_b            <= w_pB;
                    r_flg.carry    <= w_nC;
                    r_flg.msbCarry <= w_nMsb;
                end
            end
        end

        assign w_sumQ[k] = r_sum;
        assign w_aQ[k]   = r_a;
        assign w_bQ[k]   = r_b;
        assign w_flgQ[k] = r_flg;
        assign w_vQ[k]   = r_flg.valid;
    end

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Self-checking bench: directed cases plus random traffic against an arithmetic reference queue.
module tb_pipelined_adder_sub;

    localparam int W = 6;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;

    always #5 clk = ~clk;

    pipelined_adder_sub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .cin_i     (cin_i),
        .sub_i     (sub_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_o     (sum_o),
        .cout_o    (cout_o),
        .ovf_o     (ovf_o)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } result_t;

    result_t expQ[$];
    int      vectors     = 0;
    int      miscompares = 0;
    int      popCount    = 0;
    bit      lastAccepted;

    // Reference: plain integer arithmetic on the unsigned and signed readings of the operands.
    function automatic result_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        result_t r;
        int ua, ub, sa, sb, ci, uTot, sTot;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
        sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
        ci = cin ? 1 : 0;
        if (sub) begin
            uTot   = ua - ub - ci;
            sTot   = sa - sb - ci;
            r.cout = (uTot >= 0);
        end else begin
            uTot   = ua + ub + ci;
            sTot   = sa + sb + ci;
            r.cout = (uTot >= 2**W);
        end
        r.sum = uTot[W-1:0];
        r.ovf = (sTot > 2**(W-1) - 1) || (sTot < -(2**(W-1)));
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already driven at the falling edge; sample, update the model, advance.
    task automatic runCycle();
        bit accept, xfer;
        #1;
        accept = in_valid && in_ready && !rst;
        xfer   = out_valid && out_ready && !rst && !flush_i;
        if (flush_i && !rst) checkOutput("flushInReady", in_ready, 0);
        if (out_valid && !rst && !flush_i) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousValid", out_valid, 0);
            end else begin
                checkOutput("sum", sum_o, expQ[0].sum);
                checkOutput("cout", cout_o, expQ[0].cout);
                checkOutput("ovf", ovf_o, expQ[0].ovf);
            end
        end
        if (xfer && expQ.size() > 0) begin
            void'(expQ.pop_front());
            popCount++;
        end
        if (accept) expQ.push_back(refModel(a_i, b_i, cin_i, sub_i));
        lastAccepted = accept;
        if (rst || flush_i) expQ.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input logic sub, input logic valid, input logic ready,
                                 input logic flush, input logic reset);
        a_i       = a;
        b_i       = b;
        cin_i     = cin;
        sub_i     = sub;
        in_valid  = valid;
        out_ready = ready;
        flush_i   = flush;
        rst       = reset;
        runCycle();
    endtask

    task automatic idle();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Send one beat into an empty pipe, wait for it, and compare with hand-derived constants.
    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic [W-1:0] eSum,
                            input logic eCout, input logic eOvf);
        int n = 0;
        applyStimulus(a, b, cin, sub, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput({tag, "_accept"}, lastAccepted, 1);
        while (!out_valid && n < 4 * S + 4) begin
            idle();
            n++;
        end
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_sum"}, sum_o, eSum);
        checkOutput({tag, "_cout"}, cout_o, eCout);
        checkOutput({tag, "_ovf"}, ovf_o, eOvf);
        idle();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expQ.size() > 0 && n < 8 * S + 20) begin
            idle();
            n++;
        end
        checkOutput({tag, "_empty"}, expQ.size(), 0);
        checkOutput({tag, "_noValid"}, out_valid, 0);
    endtask

    // Directed steps first, then random traffic with stalls, flushes and resets.
    initial begin
        int sent, cyc, base;
        rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        @(negedge clk);

        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstSum", sum_o, 0);
        checkOutput("rstCout", cout_o, 0);
        checkOutput("rstOvf", ovf_o, 0);
        checkOutput("rstInReady", in_ready, 1);

        applyStimulus(6'd63, 6'd63, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("firstAccept", lastAccepted, 1);
        for (int i = 1; i < S; i++) begin
            checkOutput("latencyEarly", out_valid, 0);
            idle();
        end
        checkOutput("latencyOnTime", out_valid, 1);
        checkOutput("firstSum", sum_o, 63);
        checkOutput("firstCout", cout_o, 1);
        checkOutput("firstOvf", ovf_o, 0);
        idle();

        directed("subNeg", 6'd5, 6'd9, 1'b0, 1'b1, 6'd60, 1'b0, 1'b0);
        directed("subPos", 6'd9, 6'd5, 1'b0, 1'b1, 6'd4, 1'b1, 1'b0);
        directed("ovfPos", 6'd31, 6'd1, 1'b0, 1'b0, 6'd32, 1'b0, 1'b1);
        directed("ovfNeg", 6'd32, 6'd63, 1'b0, 1'b0, 6'd31, 1'b1, 1'b1);

        sent = 0;
        cyc  = 0;
        base = popCount;
        while ((sent < 8 || expQ.size() > 0) && cyc < 200) begin
            applyStimulus(W'(sent), W'(sent), 1'b0, 1'b0, sent < 8, (cyc % 3) == 0, 1'b0, 1'b0);
            if (lastAccepted) sent++;
            cyc++;
        end
        checkOutput("bpSent", sent, 8);
        checkOutput("bpDelivered", popCount - base, 8);

        applyStimulus(6'd1, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flushBeat1", lastAccepted, 1);
        applyStimulus(6'd3, 6'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flushBeat2", lastAccepted, 1);
        applyStimulus(6'd5, 6'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("flushNoAccept", lastAccepted, 0);
        checkOutput("flushOutValid", out_valid, 0);
        directed("postFlush", 6'd10, 6'd20, 1'b1, 1'b0, 6'd31, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 99) == 0);
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
